synth_poly: RTL and testbench
=============================

// Module: synth_poly
// PURPOSE
//  N-voice polyphonic synth core; successor to the single-voice oscillator/ADSR path.
//  Single clock domain. Sample and envelope rates arrive as enable strobes from the divider, not as derived clocks.
//  Accepts note-on/off events, allocates voices (retrigger, free, steal), runs per-voice ADSR + phase accumulator.
//  Produces one mixed, saturated sample per sample_en; output feeds filter/DAC.
// PARAMETERS
//  VOICES   4   number of voices (>=2)
//  PHASE_W  24  phase accumulator / increment width
//  ENV_W    8   envelope and ADSR rate width
//  TAG_W    7   note tag width (key number)
//  OUT_W    16  output sample width; must be >= ENV_W+8
// PORTS
//  clk        in   1        system clock, 20.48 MHz
//  rst        in   1        async reset, ACTIVE-LOW
//  sample_en  in   1        1-cycle strobe, sample rate (40 kHz)
//  adsr_tick  in   1        1-cycle strobe, envelope rate (78.125 Hz)
//  ev_valid   in   1        note event valid
//  ev_ready   out  1        core can accept event
//  ev_on      in   1        1=note-on, 0=note-off
//  ev_tag     in   TAG_W    note tag
//  ev_inc     in   PHASE_W  phase increment (note-on only)
//  wave_sel   in   2        00 saw, 01 square, 10 triangle, 11 = saw
//  adsr_ai, adsr_di, adsr_s, adsr_ri  in  ENV_W each  attack inc, decay dec, sustain level, release dec
//  out_data   out  OUT_W    mixed sample
//  out_valid  out  1        1-cycle strobe, out_data updated
//  voice_busy out  VOICES   bit i = voice i not IDLE
//  overrun    out  1        sticky: sample_en arrived during a scan
// BEHAVIOUR
//  Reset (rst=0): all voices IDLE, env=0, phase=0, tag=0; steal_ptr=0; out_data=0; out_valid=0; ev_ready=0; overrun=0.
//  ev_ready=1 from first clock after reset release, except during a scan. Event accepted on ev_valid&ev_ready.
//  Note-on: if a non-IDLE voice has tag==ev_tag, retrigger it: ->ATTACK, env kept, inc updated, phase kept.
//   Else the lowest-index IDLE voice: phase=0, env=0, tag/inc loaded, ->ATTACK.
//   Else steal voice steal_ptr: same load as free voice. steal_ptr increments mod VOICES, only on a steal.
//  Note-off: every non-IDLE voice with matching tag -> RELEASE. No match: ignored; event still accepted.
//  ADSR FSM per voice, advances only on adsr_tick; all arithmetic saturating, ENV_W wide:
//   ATTACK:  env+=ai; at max (2^ENV_W-1) ->DECAY. ai=0 -> env=max immediately.
//   DECAY:   env-=di, clamp at s; at env<=s ->SUSTAIN. di=0 -> env=s.
//   SUSTAIN: env=s (tracks s changes).
//   RELEASE: env-=ri, clamp at 0; at 0 ->IDLE. ri=0 -> env=0, IDLE.
//  Event and adsr_tick in the same cycle: the event wins for the targeted voice(s), whose tick is skipped. Others tick normally.
//  Oscillator: o = 8-bit from phase top bits p=phase[PHASE_W-1 -:9].
//   saw: o=p[7:0] of the top 8 bits. square: o={8{p[8]}}. triangle: o = p[8] ? ~p[7:0] : p[7:0].
//  Scan: on sample_en with no scan running, cycle 0 latches wave_sel; cycles 1..VOICES process voice i=cycle-1.
//   Each processed voice adds o_i*env_i (unsigned, ENV_W+8 bits) to the accumulator; one shared multiplier.
//   Each voice's phase+=inc (mod 2^PHASE_W) after that voice is read. IDLE voices contribute 0 and do not advance.
//   Cycle VOICES+1: out_data = min(acc, 2^OUT_W-1); out_valid=1 for exactly one cycle.
//   sample_en->out_valid latency = VOICES+1 cycles. ev_ready=0 from sample_en cycle through the out_valid cycle.
//  sample_en during a scan: ignored, overrun<=1 (sticky until reset).
//  adsr_tick during a scan: applied normally; envelope values read are those at the processing cycle.
//  Reset mid-scan: scan aborted, no out_valid, all state to reset values.
// STRUCTURE
//  Package synth_pkg: env_state_t {IDLE,ATTACK,DECAY,SUSTAIN,RELEASE}; WAVE_SAW/SQR/TRI constants.
//  Sub-module synth_voice_env: one ADSR FSM + env reg, instantiated VOICES times.
//  Top holds the allocator, phase/tag/inc arrays, scan sequencer, MAC and saturation.
// TESTING
//  1 Reset then idle: 3 sample_en -> out_valid each at +VOICES+1 cycles, out_data=0, voice_busy=0.
//  2 Note-on tag=60, ai=255: next adsr_tick env=255 (DECAY); di=255, s=128: next tick env=128 (SUSTAIN).
//     Square wave, phase MSB=1 -> out_data=255*128=32640.
//  3 Five note-ons, distinct tags, VOICES=4: voices 0-3 busy; 5th steals voice 0 (steal_ptr->1), its env=0 and phase=0.
//  4 Note-on tag=60 twice -> one voice busy (retrigger). Note-off tag=61 -> no state change.
//     Note-off tag=60, ri=255 -> IDLE after 1 tick.
//  5 Four voices at env=255, square high -> sum 260100 -> out_data=65535 (saturated).
//  6 sample_en repeated 2 cycles after a scan start -> overrun=1, single out_valid; ev_valid held in scan -> accepted after out_valid.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and the 8-bit oscillator shaper for the polyphonic synth core.
package synth_pkg;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;

  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [1:0] WAVE_SQR = 2'b01;
  localparam logic [1:0] WAVE_TRI = 2'b10;

  // p is the top 9 phase bits; code 2'b11 falls back to saw
  function automatic logic [7:0] osc_sample(input logic [8:0] p, input logic [1:0] wave);
    case (wave)
      WAVE_SQR: osc_sample = {8{p[8]}};
      WAVE_TRI: osc_sample = p[8] ? ~p[7:0] : p[7:0];
      default:  osc_sample = p[8:1];
    endcase
  endfunction

endpackage

// File: rtl/synth_voice_env.sv
// One voice envelope: ADSR state machine plus saturating envelope register.
module synth_voice_env
  import synth_pkg::*;
#(
  parameter int unsigned ENV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             clear,
  input  logic             rel,
  input  logic [ENV_W-1:0] ai,
  input  logic [ENV_W-1:0] di,
  input  logic [ENV_W-1:0] s,
  input  logic [ENV_W-1:0] ri,
  output env_state_t       state,
  output logic [ENV_W-1:0] env
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [ENV_W:0]   att_sum;
  logic             att_top;
  logic             dec_done;
  logic [ENV_W-1:0] dec_val;
  logic             rel_done;
  logic [ENV_W-1:0] rel_val;

  // Saturating next values for each ramping phase
  always_comb begin
    att_sum  = {1'b0, env} + {1'b0, ai};
    att_top  = (ai == '0) || (att_sum >= {1'b0, ENV_MAX});
    dec_done = (di == '0) || (env <= s) || ((env - s) <= di);
    dec_val  = dec_done ? s : env - di;
    rel_done = (ri == '0) || (env <= ri);
    rel_val  = rel_done ? '0 : env - ri;
  end

  // Events take priority over the envelope tick for this voice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      env   <= '0;
    end else if (start) begin
      state <= ATTACK;
      if (clear) env <= '0;
    end else if (rel) begin
      state <= RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          env <= att_top ? ENV_MAX : att_sum[ENV_W-1:0];
          if (att_top) state <= DECAY;
        end
        DECAY: begin
          env <= dec_val;
          if (dec_done) state <= SUSTAIN;
        end
        SUSTAIN: env <= s;
        RELEASE: begin
          env <= rel_val;
          if (rel_done) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/synth_poly.sv
// N-voice synth core: voice allocator, per-voice phase/envelope, serial MAC scan and saturation.
module synth_poly
  import synth_pkg::*;
#(
  parameter int unsigned VOICES  = 4,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned ENV_W   = 8,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               adsr_tick,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [TAG_W-1:0]   ev_tag,
  input  logic [PHASE_W-1:0] ev_inc,
  input  logic [1:0]         wave_sel,
  input  logic [ENV_W-1:0]   adsr_ai,
  input  logic [ENV_W-1:0]   adsr_di,
  input  logic [ENV_W-1:0]   adsr_s,
  input  logic [ENV_W-1:0]   adsr_ri,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  output logic [VOICES-1:0]  voice_busy,
  output logic               overrun
);

  localparam int unsigned IDX_W = $clog2(VOICES);
  localparam int unsigned CNT_W = $clog2(VOICES + 2);
  localparam int unsigned MUL_W = ENV_W + 8;
  localparam int unsigned SUM_W = MUL_W + $clog2(VOICES) + 1;
  localparam int unsigned ACC_W = (SUM_W > OUT_W) ? SUM_W : OUT_W + 1;

  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] inc_q   [VOICES];
  logic [TAG_W-1:0]   tag_q   [VOICES];
  env_state_t         v_state [VOICES];
  logic [ENV_W-1:0]   v_env   [VOICES];

  logic [IDX_W-1:0]  steal_ptr;
  logic              rdy_q;
  logic              scan_busy;
  logic [CNT_W-1:0]  scan_cnt;
  logic [1:0]        wave_q;
  logic [ACC_W-1:0]  acc;

  logic              accept;
  logic [VOICES-1:0] hit;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;
  logic              free_any;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  tgt_idx;
  logic              steal;
  logic [VOICES-1:0] v_start;
  logic [VOICES-1:0] v_clear;
  logic [VOICES-1:0] v_rel;

  logic [IDX_W-1:0]  cur;
  logic              proc;
  logic              cur_live;
  logic [7:0]        osc_o;
  logic [MUL_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_nxt;
  logic [OUT_W-1:0]  sat_out;

  // Events are held off for the whole scan, including the sample_en cycle itself
  assign ev_ready = rdy_q & ~scan_busy & ~sample_en;
  assign accept   = ev_valid & ev_ready;

  // Allocation: tag match first, then lowest free voice, else the steal pointer
  always_comb begin
    hit      = '0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (v_state[i] != IDLE && tag_q[i] == ev_tag) begin
        hit[i]  = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (v_state[i] == IDLE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    hit_any = |hit;
    tgt_idx = hit_any ? hit_idx : (free_any ? free_idx : steal_ptr);
    steal   = accept & ev_on & ~hit_any & ~free_any;
    for (int i = 0; i < VOICES; i++) begin
      v_start[i]    = accept & ev_on & (tgt_idx == IDX_W'(i));
      v_clear[i]    = v_start[i] & ~hit_any;
      v_rel[i]      = accept & ~ev_on & hit[i];
      voice_busy[i] = (v_state[i] != IDLE);
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    synth_voice_env #(.ENV_W(ENV_W)) u_env (
      .clk   (clk),
      .rst   (rst),
      .tick  (adsr_tick),
      .start (v_start[g]),
      .clear (v_clear[g]),
      .rel   (v_rel[g]),
      .ai    (adsr_ai),
      .di    (adsr_di),
      .s     (adsr_s),
      .ri    (adsr_ri),
      .state (v_state[g]),
      .env   (v_env[g])
    );
  end

  // Shared multiplier datapath for the voice selected by the scan counter
  always_comb begin
    cur      = IDX_W'(scan_cnt - CNT_W'(1));
    proc     = scan_busy && (scan_cnt <= CNT_W'(VOICES));
    cur_live = proc && (v_state[cur] != IDLE);
    osc_o    = osc_sample(phase_q[cur][PHASE_W-1 -: 9], wave_q);
    prod     = MUL_W'(osc_o) * MUL_W'(v_env[cur]);
    acc_nxt  = acc + (cur_live ? ACC_W'(prod) : '0);
    sat_out  = (|acc_nxt[ACC_W-1:OUT_W]) ? '1 : acc_nxt[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
      steal_ptr <= '0;
      rdy_q     <= 1'b0;
      scan_busy <= 1'b0;
      scan_cnt  <= '0;
      wave_q    <= WAVE_SAW;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      out_valid <= 1'b0;
      if (accept && ev_on) begin
        inc_q[tgt_idx] <= ev_inc;
        if (!hit_any) begin
          phase_q[tgt_idx] <= '0;
          tag_q[tgt_idx]   <= ev_tag;
        end
        if (steal) begin
          steal_ptr <= (steal_ptr == IDX_W'(VOICES - 1)) ? '0 : steal_ptr + IDX_W'(1);
        end
      end
      if (scan_busy) begin
        if (sample_en) overrun <= 1'b1;
        if (proc) begin
          if (cur_live) phase_q[cur] <= phase_q[cur] + inc_q[cur];
          acc      <= acc_nxt;
          scan_cnt <= scan_cnt + CNT_W'(1);
          if (scan_cnt == CNT_W'(VOICES)) begin
            out_data  <= sat_out;
            out_valid <= 1'b1;
          end
        end else begin
          scan_busy <= 1'b0;
          scan_cnt  <= '0;
        end
      end else if (sample_en) begin
        wave_q    <= wave_sel;
        acc       <= '0;
        scan_cnt  <= CNT_W'(1);
        scan_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synth_poly.sv
// Randomized and directed checks of synth_poly against a behavioural voice/envelope model.
module tb_synth_poly;

  localparam int V  = 4;
  localparam int PW = 24;
  localparam int EW = 8;
  localparam int TW = 7;
  localparam int OW = 16;
  localparam longint PMOD = longint'(1) << PW;
  localparam longint OMAX = (longint'(1) << OW) - 1;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic sample_en = 1'b0, adsr_tick = 1'b0, ev_valid = 1'b0, ev_on = 1'b0;
  logic [TW-1:0] ev_tag = '0;
  logic [PW-1:0] ev_inc = '0;
  logic [1:0]    wave_sel = 2'b00;
  logic [EW-1:0] ai = '0, di = '0, s = '0, ri = '0;
  logic          ev_ready, out_valid, overrun;
  logic [OW-1:0] out_data;
  logic [V-1:0]  voice_busy;

  synth_poly #(.VOICES(V), .PHASE_W(PW), .ENV_W(EW), .TAG_W(TW), .OUT_W(OW)) u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .adsr_tick(adsr_tick),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_tag(ev_tag),
    .ev_inc(ev_inc), .wave_sel(wave_sel), .adsr_ai(ai), .adsr_di(di),
    .adsr_s(s), .adsr_ri(ri), .out_data(out_data), .out_valid(out_valid),
    .voice_busy(voice_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model
  int     m_st  [V];
  int     m_env [V];
  int     m_tag [V];
  longint m_ph  [V];
  longint m_inc [V];
  int     m_steal, m_pos, m_wave, m_rdy, m_ov, m_ovr;
  longint m_acc, m_out;

  function automatic int osc(input longint ph, input int w);
    int t;
    t = int'(ph >> (PW - 9));
    if (w == 1) return (t >= 256) ? 255 : 0;
    if (w == 2) return (t >= 256) ? 255 - (t - 256) : t;
    return t / 2;
  endfunction

  function automatic longint busy_exp();
    longint b = 0;
    for (int v = 0; v < V; v++) if (m_st[v] != S_IDLE) b |= (longint'(1) << v);
    return b;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_st[v] = S_IDLE; m_env[v] = 0; m_tag[v] = 0; m_ph[v] = 0; m_inc[v] = 0;
    end
    m_steal = 0; m_pos = 0; m_wave = 0; m_rdy = 0; m_ov = 0; m_ovr = 0;
    m_acc = 0; m_out = 0;
  endtask

  task automatic adsr(input int v);
    int n;
    case (m_st[v])
      S_ATT: if (int'(ai) == 0 || m_env[v] + int'(ai) >= 255) begin
               m_env[v] = 255; m_st[v] = S_DEC;
             end else m_env[v] = m_env[v] + int'(ai);
      S_DEC: begin
               n = m_env[v] - int'(di);
               if (int'(di) == 0 || n <= int'(s)) begin m_env[v] = int'(s); m_st[v] = S_SUS; end
               else m_env[v] = n;
             end
      S_SUS: m_env[v] = int'(s);
      S_REL: begin
               n = m_env[v] - int'(ri);
               if (int'(ri) == 0 || n <= 0) begin m_env[v] = 0; m_st[v] = S_IDLE; end
               else m_env[v] = n;
             end
      default: ;
    endcase
  endtask

  task automatic model_step();
    bit tgt [V];
    bit acc_ev;
    int hit, fr, i, t;
    acc_ev = ev_valid && m_rdy != 0 && m_pos == 0 && !sample_en;
    m_ov = 0;
    if (m_pos != 0) begin
      if (sample_en) m_ovr = 1;
      if (m_pos <= V) begin
        i = m_pos - 1;
        if (m_st[i] != S_IDLE) begin
          m_acc += longint'(osc(m_ph[i], m_wave) * m_env[i]);
          m_ph[i] = (m_ph[i] + m_inc[i]) % PMOD;
        end
        if (m_pos == V) begin
          m_out = (m_acc > OMAX) ? OMAX : m_acc;
          m_ov = 1;
        end
        m_pos++;
      end else m_pos = 0;
    end else if (sample_en) begin
      m_wave = int'(wave_sel); m_acc = 0; m_pos = 1;
    end
    for (int v = 0; v < V; v++) tgt[v] = 0;
    if (acc_ev) begin
      hit = -1; fr = -1;
      for (int v = 0; v < V; v++) begin
        if (m_st[v] != S_IDLE && m_tag[v] == int'(ev_tag) && hit < 0) hit = v;
        if (m_st[v] == S_IDLE && fr < 0) fr = v;
      end
      if (!ev_on) begin
        for (int v = 0; v < V; v++)
          if (m_st[v] != S_IDLE && m_tag[v] == int'(ev_tag)) begin m_st[v] = S_REL; tgt[v] = 1; end
      end else if (hit >= 0) begin
        m_st[hit] = S_ATT; m_inc[hit] = longint'(ev_inc); tgt[hit] = 1;
      end else begin
        t = (fr >= 0) ? fr : m_steal;
        if (fr < 0) m_steal = (m_steal + 1) % V;
        m_st[t] = S_ATT; m_env[t] = 0; m_ph[t] = 0;
        m_tag[t] = int'(ev_tag); m_inc[t] = longint'(ev_inc); tgt[t] = 1;
      end
    end
    if (adsr_tick) for (int v = 0; v < V; v++) if (!tgt[v]) adsr(v);
    m_rdy = 1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_out);
      chk("ev_ready", ev_ready, (m_rdy != 0 && m_pos == 0 && !sample_en) ? 1 : 0);
      chk("voice_busy", voice_busy, busy_exp());
      chk("overrun", overrun, m_ovr);
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; sample_en = 1'b0; adsr_tick = 1'b0; ev_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    @(negedge clk);
    chk("ready_in_sample_cycle", ev_ready, 0);
    cyc();
    sample_en = 1'b0;
  endtask

  task automatic tick();
    adsr_tick = 1'b1; cyc(); adsr_tick = 1'b0;
  endtask

  task automatic send_ev(input bit on, input int tag, input longint inc);
    bit got = 0;
    ev_valid = 1'b1; ev_on = on; ev_tag = TW'(tag); ev_inc = PW'(inc);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ev_ready) begin got = 1; break; end
    end
    cyc();
    ev_valid = 1'b0;
    if (!got) chk("ev_accept_timeout", 0, 1);
  endtask

  task automatic sample_get(output longint val);
    int lat = 0;
    pulse_sample();
    for (int k = 1; k <= V + 8; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    chk("sample_latency", lat, V + 1);
    val = longint'(out_data);
    cyc();
  endtask

  function automatic logic [EW-1:0] rnd_rate();
    int r = $urandom_range(0, 5);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return EW'($urandom_range(1, 255));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint val;
    int nv, vk, ak;

    // Reset state and idle scans
    rst = 1'b0;
    cyc(); @(negedge clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ev_ready", ev_ready, 0);
    chk("rst_voice_busy", voice_busy, 0);
    chk("rst_overrun", overrun, 0);
    do_reset();
    for (int n = 0; n < 3; n++) begin
      sample_get(val);
      chk("idle_out_data", val, 0);
      chk("idle_busy", voice_busy, 0);
    end

    // Single voice through attack and decay to sustain, square wave
    do_reset();
    ai = 8'd255; di = 8'd255; s = 8'd128; ri = 8'd255; wave_sel = 2'b01;
    send_ev(1, 60, longint'(1) << 23);
    chk("t2_busy", voice_busy, 1);
    tick();
    sample_get(val); chk("t2_phase0", val, 0);
    sample_get(val); chk("t2_attack_peak", val, 65025);
    tick();
    sample_get(val); chk("t2_phase_wrap", val, 0);
    sample_get(val); chk("t2_sustain", val, 32640);

    // Steal when all voices are in use
    do_reset();
    ai = 8'd255; di = 8'd0; s = 8'd200;
    for (int t = 1; t <= 4; t++) send_ev(1, t, 1000 * t);
    chk("t3_all_busy", voice_busy, 15);
    tick();
    sample_get(val);
    chk("t3_model_phase1", m_ph[1], 2000);
    chk("t3_model_env0_pre", m_env[0], 255);
    send_ev(1, 5, longint'(1) << 23);
    chk("t3_model_steal_ptr", m_steal, 1);
    chk("t3_model_env0", m_env[0], 0);
    chk("t3_model_phase0", m_ph[0], 0);
    chk("t3_model_tag0", m_tag[0], 5);
    send_ev(1, 6, 0);
    chk("t3_model_steal_ptr2", m_steal, 2);
    chk("t3_model_tag1", m_tag[1], 6);

    // Retrigger, unmatched note-off, release to idle
    do_reset();
    ai = 8'd10; ri = 8'd255;
    send_ev(1, 60, 100);
    send_ev(1, 60, 200);
    chk("t4_retrigger_busy", voice_busy, 1);
    send_ev(0, 61, 0);
    chk("t4_nomatch_busy", voice_busy, 1);
    send_ev(0, 60, 0);
    chk("t4_release_busy", voice_busy, 1);
    tick();
    chk("t4_idle_after_tick", voice_busy, 0);

    // Four full-scale voices saturate the mix
    do_reset();
    ai = 8'd255; di = 8'd0; s = 8'd255; wave_sel = 2'b01;
    for (int t = 10; t < 14; t++) send_ev(1, t, longint'(1) << 23);
    tick();
    sample_get(val); chk("t5_phase0", val, 0);
    sample_get(val); chk("t5_saturated", val, 65535);
    chk("t5_model_acc", m_acc, 260100);

    // Overrun and event held across a scan
    do_reset();
    sample_en = 1'b1; cyc(); sample_en = 1'b0;
    ev_valid = 1'b1; ev_on = 1'b1; ev_tag = TW'(70); ev_inc = PW'(5);
    cyc();
    sample_en = 1'b1; cyc(); sample_en = 1'b0;
    nv = 0; vk = 0; ak = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin nv++; vk = k; end
      if (ev_valid && ev_ready) begin
        ak = k;
        @(posedge clk); #2;
        ev_valid = 1'b0;
      end
    end
    chk("t6_single_valid", nv, 1);
    chk("t6_overrun", overrun, 1);
    chk("t6_accept_after_valid", ak, vk + 1);
    chk("t6_busy", voice_busy, 1);

    // Reset in the middle of a scan aborts it
    do_reset();
    pulse_sample();
    cyc();
    do_reset();
    nv = 0;
    for (int k = 0; k < V + 4; k++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    cyc();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        ai = rnd_rate(); di = rnd_rate(); ri = rnd_rate(); s = EW'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 49) == 0) wave_sel = 2'($urandom_range(0, 3));
      sample_en = ($urandom_range(0, 9) == 0);
      adsr_tick = ($urandom_range(0, 4) == 0);
      ev_valid  = ($urandom_range(0, 3) == 0);
      ev_on     = ($urandom_range(0, 9) < 6);
      ev_tag    = TW'($urandom_range(0, 7));
      ev_inc    = PW'($urandom);
      cyc();
    end
    sample_en = 1'b0; adsr_tick = 1'b0; ev_valid = 1'b0;
    repeat (V + 4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
